ps2_host_tx: RTL and testbench

//  Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xF4 enable reporting, 0xED set LEDs)
//  to the keyboard or mouse over the open-collector PS/2 pair. It is the counterpart to the existing
//  PS/2 receivers in keyboard/mouse and sits beside them on the same lines in the MiST top level.

---
 rtl/ps2_pkg.sv | 29 ++
 rtl/ps2_host_tx_if.sv | 17 +
 rtl/ps2_line_filter.sv | 54 +++++
 rtl/ps2_host_tx.sv | 168 ++++++++++++++++
 tb/tb_ps2_host_tx.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module : ps2_pkg
// Brief  : Shared PS/2 host-transmit state encoding and command byte constants
// Rev    : 1.0
// ============================================================================
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    WAIT_CLK  = 3'd2,
    SHIFT     = 3'd3,
    WAIT_IDLE = 3'd4,
    ABORT     = 3'd5
  } ps2_state_t;

  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_ACK          = 8'hFA;

  // PS/2 frames carry odd parity over the eight data bits
  function automatic logic ps2_odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_host_tx_if.sv
`default_nettype none
// ============================================================================
// Module : ps2_host_tx_if
// Brief  : Command handshake between a requester and the PS/2 host transmitter
// Rev    : 1.0
// ============================================================================
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_strobe;
  logic       busy;
  logic       done;
  logic       error;

  modport master (output tx_data, output tx_strobe, input busy, input done, input error);
  modport slave  (input tx_data, input tx_strobe, output busy, output done, output error);
endinterface
`default_nettype wire

// File: rtl/ps2_line_filter.sv
`default_nettype none
// ============================================================================
// Module : ps2_line_filter
// Brief  : 2-FF synchroniser, stability debounce and falling-edge pulse for one PS/2 line
// Rev    : 1.0
// ============================================================================
module ps2_line_filter #(
  parameter int FILT_LEN = 16
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic line_in,
  output logic level,
  output logic fall
);

  localparam int c_cnt_w = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(FILT_LEN - 1);

  logic               r_meta;
  logic               r_sync;
  logic               r_level;
  logic               r_fall;
  logic [c_cnt_w-1:0] r_cnt;

  // Idle bus is pulled high, so the filtered level starts released
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_meta  <= 1'b1;
      r_sync  <= 1'b1;
      r_level <= 1'b1;
      r_fall  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_meta <= line_in;
      r_sync <= r_meta;
      r_fall <= 1'b0;
      if (r_sync == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == c_cnt_max) begin
        r_level <= r_sync;
        r_fall  <= r_level;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign level = r_level;
  assign fall  = r_fall;

endmodule
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module : ps2_host_tx
// Brief  : Host-to-device PS/2 command byte transmitter driving open-collector pull-low enables
// Rev    : 1.0
// ============================================================================
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ      = 96_000_000,
  parameter int INHIBIT_US  = 120,
  parameter int START_TO_US = 15000,
  parameter int BIT_TO_US   = 2000,
  parameter int FILT_LEN    = 16
) (
  input  logic          clk_sys,
  input  logic          reset,
  ps2_host_tx_if.slave  host,
  input  logic          ps2_clk_in,
  input  logic          ps2_dat_in,
  output logic          ps2_clk_oe,
  output logic          ps2_dat_oe
);

  localparam int c_cyc_per_us = CLK_HZ / 1_000_000;
  localparam int c_tmr_w      = $clog2(c_cyc_per_us * START_TO_US) + 1;
  localparam logic [c_tmr_w-1:0] c_inhibit_cyc = c_tmr_w'(c_cyc_per_us * INHIBIT_US);
  localparam logic [c_tmr_w-1:0] c_start_cyc   = c_tmr_w'(c_cyc_per_us * START_TO_US);
  localparam logic [c_tmr_w-1:0] c_bit_cyc     = c_tmr_w'(c_cyc_per_us * BIT_TO_US);

  logic w_clk_level;
  logic w_clk_fall;
  logic w_dat_level;
  logic w_unused_dat_fall;

  ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_clk_filt (
    .clk_sys (clk_sys),
    .reset   (reset),
    .line_in (ps2_clk_in),
    .level   (w_clk_level),
    .fall    (w_clk_fall)
  );

  // Data edges carry no meaning for the transmitter; only the level is sampled
  ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_dat_filt (
    .clk_sys (clk_sys),
    .reset   (reset),
    .line_in (ps2_dat_in),
    .level   (w_dat_level),
    .fall    (w_unused_dat_fall)
  );

  ps2_state_t         r_state;
  logic [c_tmr_w-1:0] r_timer;
  logic [3:0]         r_bit_cnt;
  logic [7:0]         r_data;
  logic               r_parity;
  logic               r_clk_oe;
  logic               r_dat_oe;
  logic               r_busy;
  logic               r_done;
  logic               r_error;
  logic [3:0]         w_next_n;

  assign w_next_n = r_bit_cnt + 4'd1;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_timer   <= '0;
      r_bit_cnt <= '0;
      r_data    <= '0;
      r_parity  <= 1'b0;
      r_clk_oe  <= 1'b0;
      r_dat_oe  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;
      case (r_state)
        IDLE: begin
          // A strobe coinciding with a completion pulse is dropped
          if (host.tx_strobe && !r_done && !r_error) begin
            r_data    <= host.tx_data;
            r_parity  <= ps2_odd_parity(host.tx_data);
            r_clk_oe  <= 1'b1;
            r_busy    <= 1'b1;
            r_timer   <= c_inhibit_cyc;
            r_bit_cnt <= '0;
            r_state   <= INHIBIT;
          end
        end
        INHIBIT: begin
          // Start bit goes low one cycle before the clock is released
          if (r_timer != '0) begin
            r_timer <= r_timer - 1'b1;
          end else if (!r_dat_oe) begin
            r_dat_oe <= 1'b1;
          end else begin
            r_clk_oe <= 1'b0;
            r_timer  <= c_start_cyc;
            r_state  <= WAIT_CLK;
          end
        end
        WAIT_CLK: begin
          if (w_clk_fall) begin
            r_dat_oe  <= ~r_data[0];
            r_bit_cnt <= 4'd1;
            r_timer   <= c_bit_cyc;
            r_state   <= SHIFT;
          end else if (r_timer == '0) begin
            r_state <= ABORT;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        SHIFT: begin
          if (w_clk_fall) begin
            r_bit_cnt <= w_next_n;
            r_timer   <= c_bit_cyc;
            if (w_next_n <= 4'd8) begin
              r_dat_oe <= ~r_data[r_bit_cnt[2:0]];
            end else if (w_next_n == 4'd9) begin
              r_dat_oe <= ~r_parity;
            end else if (w_next_n == 4'd10) begin
              r_dat_oe <= 1'b0;
            end else begin
              r_state <= w_dat_level ? ABORT : WAIT_IDLE;
            end
          end else if (r_timer == '0) begin
            r_state <= ABORT;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        WAIT_IDLE: begin
          if (w_clk_level && w_dat_level) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else if (r_timer == '0) begin
            r_state <= ABORT;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        ABORT: begin
          r_clk_oe <= 1'b0;
          r_dat_oe <= 1'b0;
          r_busy   <= 1'b0;
          r_error  <= 1'b1;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ps2_clk_oe = r_clk_oe;
  assign ps2_dat_oe = r_dat_oe;
  assign host.busy  = r_busy;
  assign host.done  = r_done;
  assign host.error = r_error;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module : tb_ps2_host_tx
// Brief  : Scoreboard bench for ps2_host_tx with an open-collector PS/2 device model
// Rev    : 1.0
// ============================================================================
module tb_ps2_host_tx;

  // 4 cycles per microsecond keeps the timeouts short enough to simulate
  localparam int c_clk_hz  = 4_000_000;
  localparam int c_inh_cyc = 480;
  localparam int c_start_cyc = 4000;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  logic dev_clk_low = 1'b0;
  logic dev_dat_low = 1'b0;
  logic ps2_clk_in, ps2_dat_in, ps2_clk_oe, ps2_dat_oe;
  logic [10:0] cap_frame;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [10:0] frame;
    int          nbits;
    bit          is_done;
  } exp_t;
  exp_t sb[$];

  ps2_host_tx_if hif();

  ps2_host_tx #(
    .CLK_HZ(c_clk_hz), .INHIBIT_US(120), .START_TO_US(1000), .BIT_TO_US(200), .FILT_LEN(16)
  ) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .host       (hif),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe)
  );

  always #5 clk_sys = ~clk_sys;

  assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: actual %0d required %0d..%0d", name, act, lo, hi);
  endtask

  task automatic push(input logic [10:0] frame, input int nbits, input bit is_done);
    exp_t e;
    e.frame = frame; e.nbits = nbits; e.is_done = is_done;
    sb.push_back(e);
  endtask

  task automatic send(input logic [7:0] d);
    @(negedge clk_sys);
    hif.tx_data = d; hif.tx_strobe = 1'b1;
    @(negedge clk_sys);
    hif.tx_strobe = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    repeat (3) @(negedge clk_sys);
    while (hif.busy && t < 20000) begin @(negedge clk_sys); t++; end
    if (hif.busy) chk("busy_timeout", 32'(hif.busy), 0);
    repeat (40) @(negedge clk_sys);
  endtask

  // Device: answers the request-to-send, clocks nfalls falls and records dat_oe per bit
  task automatic dev_run(input int nfalls, input bit ack, input bit glitch, output int inh_cycles);
    int t = 0;
    inh_cycles = 0;
    cap_frame  = '0;
    while (!ps2_clk_oe && t < 2000) begin @(negedge clk_sys); t++; end
    while (ps2_clk_oe && t < 4000) begin @(negedge clk_sys); inh_cycles++; t++; end
    cap_frame[0] = ps2_dat_oe;
    if (glitch) begin
      repeat (3) begin
        repeat (20) @(negedge clk_sys);
        dev_clk_low = 1'b1;
        repeat (3) @(negedge clk_sys);
        dev_clk_low = 1'b0;
      end
    end
    repeat (40) @(negedge clk_sys);
    for (int n = 1; n <= nfalls; n++) begin
      dev_clk_low = 1'b1;
      repeat (100) @(negedge clk_sys);
      if (n <= 10) cap_frame[n] = ps2_dat_oe;
      repeat (60) @(negedge clk_sys);
      dev_clk_low = 1'b0;
      repeat (80) @(negedge clk_sys);
      if (n == 10 && ack) dev_dat_low = 1'b1;
      repeat (80) @(negedge clk_sys);
    end
    dev_dat_low = 1'b0;
  endtask

  // Monitor: every done/error pulse consumes one scoreboard entry
  always @(negedge clk_sys) begin
    exp_t        e;
    logic [10:0] m;
    if (!reset && (hif.done || hif.error)) begin
      chk("pulse_exclusive", 32'(hif.done & hif.error), 0);
      chk("busy_low_on_pulse", 32'(hif.busy), 0);
      chk("lines_released", 32'({ps2_clk_oe, ps2_dat_oe}), 0);
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_pulse: actual done=%0b error=%0b required no pulse", hif.done, hif.error);
      end else begin
        e = sb.pop_front();
        chk("outcome_done", 32'(hif.done), 32'(e.is_done));
        if (e.nbits > 0) begin
          m = (e.nbits >= 11) ? 11'h7FF : 11'((12'd1 << e.nbits) - 12'd1);
          chk("frame_dat_oe", 32'(cap_frame & m), 32'(e.frame & m));
        end
      end
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: actual no finish required finish");
    $fatal(1);
  end

  initial begin
    int inh;
    int t;
    bit saw_busy;
    hif.tx_data   = 8'h00;
    hif.tx_strobe = 1'b0;

    repeat (3) @(negedge clk_sys);
    chk("reset_busy", 32'(hif.busy), 0);
    chk("reset_done_error", 32'({hif.done, hif.error}), 0);
    chk("reset_lines", 32'({ps2_clk_oe, ps2_dat_oe}), 0);
    reset = 1'b0;
    repeat (10) @(negedge clk_sys);

    // Device-initiated clocking while idle must not start anything
    saw_busy = 1'b0;
    repeat (3) begin
      dev_clk_low = 1'b1;
      repeat (160) begin @(negedge clk_sys); saw_busy |= hif.busy; end
      dev_clk_low = 1'b0;
      repeat (160) begin @(negedge clk_sys); saw_busy |= hif.busy; end
    end
    chk("idle_traffic_busy", 32'(saw_busy), 0);

    // 0xF4: start 1, ~data 1,1,0,1,0,0,0,0, ~parity 1, stop 0
    push(11'h217, 11, 1'b1);
    fork
      send(8'hF4);
      dev_run(11, 1'b1, 1'b0, inh);
    join
    chk("busy_during_ack_wait", 32'(hif.busy), 1);
    wait_idle();

    // 0x00: all data released-low, parity 1 so dat_oe 0 at fall 9
    push(11'h1FF, 11, 1'b1);
    fork
      send(8'h00);
      dev_run(11, 1'b1, 1'b0, inh);
    join
    chk_range("inhibit_len", inh, c_inh_cyc, c_inh_cyc + 40);
    wait_idle();

    // Device never clocks: start timeout
    push(11'h000, 0, 1'b0);
    send(8'hFF);
    t = 0;
    while (ps2_clk_oe && t < 2000) begin @(negedge clk_sys); t++; end
    t = 0;
    while (!hif.error && t < 8000) begin @(negedge clk_sys); t++; end
    chk_range("start_timeout_cycles", t, c_start_cyc - 16, c_start_cyc + 20);
    wait_idle();

    // Device stops after five falls: bit timeout
    push(11'h217, 6, 1'b0);
    fork
      send(8'hF4);
      dev_run(5, 1'b0, 1'b0, inh);
    join
    wait_idle();

    // 0xFF without ACK: start 1, ~data all 0, ~parity 0, stop 0
    push(11'h001, 11, 1'b0);
    fork
      send(8'hFF);
      dev_run(11, 1'b0, 1'b0, inh);
    join
    wait_idle();

    // Strobe 0xED while busy: ignored, 0xF4 frame unchanged
    push(11'h217, 11, 1'b1);
    fork
      begin
        send(8'hF4);
        repeat (30) @(negedge clk_sys);
        send(8'hED);
      end
      dev_run(11, 1'b1, 1'b0, inh);
    join
    wait_idle();

    // Reset mid-SHIFT: outputs drop without waiting for a clock edge
    fork
      send(8'hF4);
      dev_run(4, 1'b0, 1'b0, inh);
    join
    repeat (30) @(negedge clk_sys);
    chk("pre_reset_busy", 32'(hif.busy), 1);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_lines", 32'({ps2_clk_oe, ps2_dat_oe}), 0);
    chk("async_reset_busy", 32'(hif.busy), 0);
    @(negedge clk_sys);
    reset = 1'b0;
    repeat (20) @(negedge clk_sys);

    // 0xED after reset: start 1, ~data 0,1,0,0,1,0,0,0, ~parity 0, stop 0
    push(11'h025, 11, 1'b1);
    fork
      send(8'hED);
      dev_run(11, 1'b1, 1'b0, inh);
    join
    wait_idle();

    // Short clock glitches before the first real fall must not shift the frame
    push(11'h1FF, 11, 1'b1);
    fork
      send(8'h00);
      dev_run(11, 1'b1, 1'b1, inh);
    join
    wait_idle();

    repeat (50) @(negedge clk_sys);
    chk("scoreboard_drained", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
